// File: rtl/mips_div_pkg.sv
// Shared definitions for the multi-cycle divide sequencer: state encoding,
// default operand width and the iteration counter width.
package mips_div_pkg;

    localparam int DIV_WIDTH = 32;

    // The counter is wide enough to index WIDTH iterations and never narrower than one bit.
    function automatic int divCntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DIV_CNT_W = divCntWidth(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divState_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide step on unsigned magnitudes (purely combinational).
module div_step
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] remShift;
    logic [WIDTH:0] trial;

    // The partial remainder stays below twice the divisor, so the top bit of
    // the WIDTH+1-bit difference is a reliable borrow flag.
    always_comb begin
        remShift = {rem_i, quo_i[WIDTH-1]};
        trial    = remShift - {1'b0, divisor_i};
        quo_o    = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
        rem_o    = trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer for the execute stage: holds the pipeline while
// dividing, then pulses done with hi/lo. Signed ops need `define SIGNED_DIV_EN.
module div_sequencer
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sign_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o,
    output logic             busy_o
);

    localparam int CNT_W = divCntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    divState_e        state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             negQuo_q;
    logic             negRem_q;
    logic             divZero_q;

    logic [WIDTH-1:0] stepRem_d;
    logic [WIDTH-1:0] stepQuo_d;

    logic             signedOp;
    logic             opaNeg;
    logic             opbNeg;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

`ifdef SIGNED_DIV_EN
    assign signedOp = sign_i;
`else
    logic unusedSign;
    assign unusedSign = sign_i;
    assign signedOp   = 1'b0;
`endif

    // The core always divides magnitudes; the signs are reapplied in FIX.
    assign opaNeg = signedOp & opa_i[WIDTH-1];
    assign opbNeg = signedOp & opb_i[WIDTH-1];
    assign magA   = opaNeg ? (~opa_i + 1'b1) : opa_i;
    assign magB   = opbNeg ? (~opb_i + 1'b1) : opb_i;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(divisor_q),
        .rem_o    (stepRem_d),
        .quo_o    (stepQuo_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
        end else if (cancel_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        count_q <= '0;
                        if (opb_i == '0) begin
                            hi_q      <= opa_i;
                            lo_q      <= '1;
                            divZero_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= magA;
                            divisor_q <= magB;
                            negQuo_q  <= opaNeg ^ opbNeg;
                            negRem_q  <= opaNeg;
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q   <= stepRem_d;
                    quo_q   <= stepQuo_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // Most-negative / -1 wraps back to most-negative here on purpose.
                    lo_q      <= negQuo_q ? (~quo_q + 1'b1) : quo_q;
                    hi_q      <= negRem_q ? (~rem_q + 1'b1) : rem_q;
                    divZero_q <= 1'b0;
                    state_q   <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_o    = ((state_q == IDLE) & start_i & ~cancel_i)
                      | (state_q == RUN) | (state_q == FIX);
    assign done_o     = (state_q == DONE);
    assign busy_o     = (state_q != IDLE);
    assign div_zero_o = divZero_q & done_o;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle divide sequencer for the pipelined MIPS core. It takes a DIV/DIVU issued from the execute stage and runs a radix-2 restoring divide over WIDTH cycles. While it runs, it holds the pipeline through a stall request, then presents quotient/remainder for a single-cycle HI/LO write. It sits beside the ALU in the execute stage; it is driven by the controller's decode of div ops and feeds the hazard unit and the HI/LO register.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  reset. Asynchronous assert, active-low (0 = reset), synchronous release externally.
- start  in  1  execute stage holds a div op this cycle (already qualified by controller)
- sign  in  1  1 = DIV (signed), 0 = DIVU
- opa  in  WIDTH  dividend (rs), sampled when start accepted
- opb  in  WIDTH  divisor (rt), sampled when start accepted
- cancel  in  1  flush of the execute stage; aborts the operation
- stall  out  1  hold fetch/decode/execute; combinational
- done  out  1  one-cycle pulse, hi/lo valid, drives HI/LO write enable
- hi  out  WIDTH  remainder
- lo  out  WIDTH  quotient
- div_zero  out  1  divisor was zero; valid with done
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start & ~cancel: latch operands, go to RUN with count = 0.
  - If opb = 0, go directly to DONE instead.
- RUN: one restoring step per cycle on magnitudes.
  - Shift {rem, quo} left 1.
  - Trial-subtract divisor from rem (WIDTH+1-bit subtract).
  - Keep the result and set quo LSB if non-negative.
  - Go to FIX when count = WIDTH-1.
- FIX: apply sign correction.
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - Go to DONE.
- DONE: done = 1, then IDLE.
- Divide by zero: lo = all ones, hi = opa, div_zero = 1.
- Signed overflow (most-negative / -1): lo = most-negative value, hi = 0. This is the natural WIDTH-bit wrap of magnitude arithmetic, with no special case.
- cancel in any state: IDLE at next edge; no done, hi/lo unchanged.
- cancel together with start: cancel wins; nothing accepted.
- start while busy: ignored. It cannot legally occur because stall is high.
- hi/lo hold the last result until the next DONE.

## Timing
- Reset values: state IDLE, count 0; stall, done, div_zero, busy = 0; hi = lo = 0.
- The start cycle is cycle 0.
- Normal op:
  - RUN occupies cycles 1..WIDTH.
  - FIX is cycle WIDTH+1.
  - DONE is cycle WIDTH+2, i.e. cycle 34 for WIDTH = 32.
- stall = (IDLE & start & ~cancel) | RUN | FIX.
  - It is high for cycles 0..WIDTH+1 and low in the DONE cycle, so the div instruction leaves execute with done.
- Divide by zero: DONE in cycle 1; stall is high in cycle 0 only.
- Reset mid-operation forces all outputs to their reset values immediately, independent of clk.

## Configuration
- SIGNED_DIV_EN defined: signed path as above (abs on entry, FIX correction).
- SIGNED_DIV_EN undefined:
  - sign is ignored; every op is unsigned.
  - FIX still takes one cycle, and latency is identical.

## Structure
- Shared package mips_div_pkg holds:
  - The state enum (IDLE, RUN, FIX, DONE).
  - The WIDTH default.
  - The count width, $clog2(WIDTH).
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once; the sequencer owns all registers.

## Test plan
- DIVU 100 / 7 → done in cycle 34, lo = 14, hi = 2; stall high cycles 0–33, low in 34.
- DIV 0xFFFFFFF9 (-7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. With SIGNED_DIV_EN undefined: lo = 0x7FFFFFFC, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_zero = 0.
- DIVU 5 / 0 → done in cycle 1, div_zero = 1, lo = 0xFFFFFFFF, hi = 5.
- Cancel in cycle 10 → IDLE and stall = 0 in cycle 11, no done, hi/lo unchanged. New start 144 / 12 in cycle 12 → done in cycle 46, lo = 12, hi = 0.
- rst low in cycle 20 of a RUN → stall, busy, done, hi, lo = 0 immediately. After release, IDLE; the next start completes normally.
